// File: rtl/execute_out_fifo_pkg.sv
// ============================================================================
//  Module      : execute_out_fifo_pkg
//  Description : Bundle layout, field offsets, pack/unpack helpers and FSM
//                state encodings for the execute-stage output FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package execute_out_fifo_pkg;

   localparam int W_CONTROL_W   = 2;
   localparam int MEM_CONTROL_W = 1;
   localparam int NZP_W         = 3;

   localparam int DATA_W_DEF = 16;
   localparam int RA_W_DEF   = 3;

   function automatic int bundle_w(input int data_w, input int ra_w);
      return W_CONTROL_W + MEM_CONTROL_W + 4*data_w + 3*ra_w + NZP_W;
   endfunction

   // Field LSB offsets; M_Data occupies the bottom of the bundle.
   function automatic int off_m_data(input int data_w);
      return 0 * data_w;
   endfunction
   function automatic int off_nzp(input int data_w);
      return data_w;
   endfunction
   function automatic int off_ir_exec(input int data_w);
      return data_w + NZP_W;
   endfunction
   function automatic int off_sr2(input int data_w);
      return 2*data_w + NZP_W;
   endfunction
   function automatic int off_sr1(input int data_w, input int ra_w);
      return 2*data_w + NZP_W + ra_w;
   endfunction
   function automatic int off_dr(input int data_w, input int ra_w);
      return 2*data_w + NZP_W + 2*ra_w;
   endfunction
   function automatic int off_pcout(input int data_w, input int ra_w);
      return 2*data_w + NZP_W + 3*ra_w;
   endfunction
   function automatic int off_aluout(input int data_w, input int ra_w);
      return 3*data_w + NZP_W + 3*ra_w;
   endfunction
   function automatic int off_mem_control(input int data_w, input int ra_w);
      return 4*data_w + NZP_W + 3*ra_w;
   endfunction
   function automatic int off_w_control(input int data_w, input int ra_w);
      return 4*data_w + NZP_W + 3*ra_w + MEM_CONTROL_W;
   endfunction

   localparam int BUNDLE_W_DEF   = bundle_w(DATA_W_DEF, RA_W_DEF);
   localparam int OFF_ALUOUT_DEF = off_aluout(DATA_W_DEF, RA_W_DEF);

   typedef struct packed {
      logic [W_CONTROL_W-1:0]   w_control;
      logic [MEM_CONTROL_W-1:0] mem_control;
      logic [DATA_W_DEF-1:0]    aluout;
      logic [DATA_W_DEF-1:0]    pcout;
      logic [RA_W_DEF-1:0]      dr;
      logic [RA_W_DEF-1:0]      sr1;
      logic [RA_W_DEF-1:0]      sr2;
      logic [DATA_W_DEF-1:0]    ir_exec;
      logic [NZP_W-1:0]         nzp;
      logic [DATA_W_DEF-1:0]    m_data;
   } exec_bundle_t;

   function automatic exec_bundle_t pack_bundle(
      input logic [W_CONTROL_W-1:0]   w_control,
      input logic [MEM_CONTROL_W-1:0] mem_control,
      input logic [DATA_W_DEF-1:0]    aluout,
      input logic [DATA_W_DEF-1:0]    pcout,
      input logic [RA_W_DEF-1:0]      dr,
      input logic [RA_W_DEF-1:0]      sr1,
      input logic [RA_W_DEF-1:0]      sr2,
      input logic [DATA_W_DEF-1:0]    ir_exec,
      input logic [NZP_W-1:0]         nzp,
      input logic [DATA_W_DEF-1:0]    m_data
   );
      exec_bundle_t b;
      b.w_control   = w_control;
      b.mem_control = mem_control;
      b.aluout      = aluout;
      b.pcout       = pcout;
      b.dr          = dr;
      b.sr1         = sr1;
      b.sr2         = sr2;
      b.ir_exec     = ir_exec;
      b.nzp         = nzp;
      b.m_data      = m_data;
      return b;
   endfunction

   function automatic exec_bundle_t unpack_bundle(input logic [BUNDLE_W_DEF-1:0] raw);
      return exec_bundle_t'(raw);
   endfunction

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_PART  = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/execute_out_fifo_mem.sv
// ============================================================================
//  Module      : execute_out_fifo_mem
//  Description : DEPTH x WIDTH register array, synchronous write, async read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_out_fifo_mem
   import execute_out_fifo_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 79,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/execute_out_fifo.sv
// ============================================================================
//  Module      : execute_out_fifo
//  Description : Elastic valid/ready buffer for execute-stage result bundles
//                with flush and occupancy reporting. Optional statistics
//                outputs are enabled by defining EXECUTE_OUT_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_out_fifo
   import execute_out_fifo_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int RA_W   = 3,
   parameter int DEPTH  = 4,
   localparam int BUNDLE_W = bundle_w(DATA_W, RA_W),
   localparam int CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BUNDLE_W-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BUNDLE_W-1:0] out_data,
   output logic [CNT_W-1:0]    count,
`ifdef EXECUTE_OUT_STATS_EN
   output logic [15:0]         push_cnt,
   output logic [15:0]         stall_cnt,
   output logic [CNT_W-1:0]    max_count,
`endif
   output logic                full,
   output logic                empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [1:0]          state_q, state_d;
   logic                push, pop, mem_wr_en;
   logic [BUNDLE_W-1:0] head_data;

   execute_out_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (BUNDLE_W)
   ) u_mem (
      .clock   (clock),
      .wr_en   (mem_wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (in_data),
      .rd_addr (rd_ptr_q),
      .rd_data (head_data)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= ST_EMPTY;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
      end
   end

   // Flush wins over push/pop; a discarded push must not touch storage either.
   always_comb begin
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
      mem_wr_en = push && !flush;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      state_d   = state_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         state_d  = ST_EMPTY;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         case (state_q)
            ST_EMPTY: begin
               if (push) state_d = ST_PART;
            end
            ST_PART: begin
               if (push && !pop && count_q == CNT_W'(DEPTH - 1)) begin
                  state_d = ST_FULL;
               end else if (pop && !push && count_q == CNT_W'(1)) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (pop) state_d = ST_PART;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      empty     = (state_q == ST_EMPTY);
      full      = (state_q == ST_FULL);
      in_ready  = !full;
      out_valid = !empty;
      out_data  = empty ? '0 : head_data;
      count     = count_q;
   end

`ifdef EXECUTE_OUT_STATS_EN
   logic [15:0]      push_cnt_q, push_cnt_d;
   logic [15:0]      stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] max_count_q, max_count_d;

   // The high-water mark survives a flush; the event counters do not.
   always_comb begin
      push_cnt_d  = flush ? 16'd0 : push_cnt_q + 16'(push);
      stall_cnt_d = flush ? 16'd0 : stall_cnt_q + 16'(in_valid && !in_ready);
      max_count_d = (count_d > max_count_q) ? count_d : max_count_q;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         push_cnt_q  <= '0;
         stall_cnt_q <= '0;
         max_count_q <= '0;
      end else begin
         push_cnt_q  <= push_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         max_count_q <= max_count_d;
      end
   end

   assign push_cnt  = push_cnt_q;
   assign stall_cnt = stall_cnt_q;
   assign max_count = max_count_q;
`endif

`ifndef SYNTHESIS
   a_no_push_full: assert property (@(posedge clock) disable iff (!reset)
      !(push && full));
   a_out_stable: assert property (@(posedge clock) disable iff (!reset)
      (out_valid && !out_ready && !flush) |=> $stable(out_data));
   a_count_max: assert property (@(posedge clock) disable iff (!reset)
      count_q <= CNT_W'(DEPTH));
`endif

endmodule

`default_nettype wire

// File: doc/execute_out_fifo.md
Name: execute_out_fifo

Overview:
Parametrised elastic buffer for execute-stage result bundles (W_Control, Mem_Control, aluout, pcout, dr, sr1, sr2, IR_Exec, NZP, M_Data). It sits between execute and memaccess/writeback and decouples them with valid/ready handshakes on both sides. It replaces the fixed single-register execute output with configurable data width, register-address width and depth. It adds flush and occupancy reporting.

Parameters:
DATA_W, 16, width of aluout, pcout, IR_Exec and M_Data fields
RA_W, 3, width of dr, sr1 and sr2 register-address fields
DEPTH, 4, number of bundle entries; power of two, at least 2
BUNDLE_W, 2+1+4*DATA_W+3*RA_W+3, derived, not overridable; 79 at defaults

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
flush  input  1  drop all stored entries; synchronous
in_valid  input  1  upstream offers a bundle
in_ready  output  1  buffer accepts; equals !full
in_data  input  BUNDLE_W  packed bundle, layout from package
out_valid  output  1  head entry is valid; equals !empty
out_ready  input  1  downstream takes the head entry
out_data  output  BUNDLE_W  head entry; all zeros when empty
count  output  $clog2(DEPTH)+1  number of occupied entries
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset (reset == 0 at a clock edge) sets wr_ptr = rd_ptr = count = 0, so empty = 1, full = 0, in_ready = 1, out_valid = 0, out_data = 0. Storage contents are not reset.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Latency: a bundle pushed in cycle N is visible on out_data, with out_valid = 1, in cycle N+1. There is no combinational in-to-out path.
- out_data is driven from registered head storage, gated to zero when empty.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is updated in the same cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full: in_ready = 0 and any in_valid is ignored. A pop while full frees one slot for the next cycle only; in_ready is not combinationally dependent on out_ready.
- Empty: out_valid = 0 and out_ready is ignored. A push while empty is not bypassed.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and count holds.
- Flush has priority over push and pop in the same cycle: pointers and count go to 0 and the concurrent push is discarded.
- Reset has priority over flush. Reset mid-stream discards all entries; in_ready = 1 on the first cycle after reset releases.
- Assertions (sim only):
  - no push while full;
  - out_data stable while out_valid && !out_ready;
  - count <= DEPTH.
- Control FSM: count encodes the state, with three derived states.
  - EMPTY: push -> PART, or FULL if DEPTH == 1; DEPTH == 1 is disallowed.
  - PART: push only at count == DEPTH-1 -> FULL; pop only at count == 1 -> EMPTY.
  - FULL: pop -> PART.
  - flush -> EMPTY from any state.

Optional Feature:
Macro EXECUTE_OUT_STATS_EN.
- Defined: adds three outputs, each wrapping at 2^16.
  - push_cnt [15:0]: accepted pushes.
  - stall_cnt [15:0]: cycles with in_valid && !in_ready.
  - max_count [$clog2(DEPTH):0]: high-water mark of count.
- All three reset to 0. flush clears push_cnt and stall_cnt but not max_count.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package execute_out_fifo_pkg holds:
  - localparam field offsets;
  - the BUNDLE_W function of DATA_W and RA_W;
  - W_CONTROL_W = 2, NZP_W = 3;
  - pack/unpack functions for the bundle, field order MSB to LSB: W_Control, Mem_Control, aluout, pcout, dr, sr1, sr2, IR_Exec, NZP, M_Data.
- One sub-module, execute_out_fifo_mem: DEPTH x BUNDLE_W register array with a synchronous write port and an asynchronous read port.
- Pointer, count and flag logic stays in the top module.

Test Plan:
- Reset with in_valid = 1 held -> after release count = 0, empty = 1, out_data = 0; first push of aluout = 16'h1234 appears on out_data one cycle later.
- Push 4 bundles (aluout = 1,2,3,4) with out_ready = 0 at DEPTH = 4 -> full = 1, in_ready = 0; a fifth push is ignored; drain yields 1,2,3,4 in order.
- Continuous push and pop at count = 2 for 20 cycles -> count stays 2, ordering preserved, pointers wrap past 3 -> 0 correctly.
- Pop while full plus in_valid in the same cycle -> push refused that cycle, accepted next cycle, count sequence 4,3,4.
- flush asserted with in_valid = 1 and count = 3 -> next cycle count = 0, empty = 1, the concurrent bundle is absent from the output.
- With EXECUTE_OUT_STATS_EN, DATA_W = 32, DEPTH = 8: 10 pushes including 3 stalled cycles -> push_cnt = 10, stall_cnt = 3, max_count = 8.
